div_ctrl: RTL and testbench

Iterative RV32M divider with its sequencing FSM, located in the EX stage next to the ALU. It takes DIV/DIVU/REM/REMU operands from the ID→EX pipeline registers and runs a 32-step radix-2 restoring division. Divide-by-zero and signed overflow are resolved in one cycle. It returns the result to EX with a one-cycle done pulse, and EX stalls its pipe until that pulse. A downstream flush aborts it.

---
 rtl/div_ctrl_pkg.sv | 24 ++
 rtl/div_ctrl_if.sv | 26 ++
 rtl/div_step_dp.sv | 49 ++++
 rtl/div_ctrl.sv | 127 ++++++++++++
 tb/tb_div_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared widths, opcode encodings and helpers for the iterative RV32M divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package div_ctrl_pkg;

   localparam int XLEN         = 32;
   localparam int MUL_OP_WIDTH = 2;
   localparam int DIV_CYCLES   = 32;
   localparam int CNT_W        = $clog2(DIV_CYCLES);

   // Bit 1 selects remainder, bit 0 selects unsigned.
   typedef enum logic [MUL_OP_WIDTH-1:0] {
      DIV_OP_DIV  = 2'd0,
      DIV_OP_DIVU = 2'd1,
      DIV_OP_REM  = 2'd2,
      DIV_OP_REMU = 2'd3
   } div_op_e;

   // Two's-complement negate when requested.
   function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// EX-stage <-> divider request/result bundle.
// Latency: n/a (wiring only).
// Backpressure: requester holds div_req and operands until div_done.
interface div_ctrl_if;
   import div_ctrl_pkg::*;

   logic            div_req;
   div_op_e         div_opcode;
   logic [XLEN-1:0] div_dividend;
   logic [XLEN-1:0] div_divisor;
   logic            div_flush;
   logic            div_busy;
   logic            div_done;
   logic [XLEN-1:0] div_result;

   modport master (
      output div_req, div_opcode, div_dividend, div_divisor, div_flush,
      input  div_busy, div_done, div_result
   );

   modport slave (
      input  div_req, div_opcode, div_dividend, div_divisor, div_flush,
      output div_busy, div_done, div_result
   );

endinterface

// File: rtl/div_step_dp.sv
// Restoring-division datapath: quotient/remainder/divisor registers and 33-bit trial subtractor.
// Latency: one quotient bit per step cycle; quo_nxt/rem_nxt show the result of the current step.
// Backpressure: none; advances only when step is asserted by the controller.
module div_step_dp
   import div_ctrl_pkg::*;
(
   input  logic            clk,
   input  logic            rst_b,
   input  logic            load,
   input  logic            step,
   input  logic [XLEN-1:0] dividend_mag,
   input  logic [XLEN-1:0] divisor_mag,
   output logic [XLEN-1:0] quo_nxt,
   output logic [XLEN-1:0] rem_nxt
);

   logic [XLEN-1:0] quo;
   logic [XLEN-1:0] rem;
   logic [XLEN-1:0] dvs;
   logic [XLEN:0]   trial;

   // Shift in the next dividend bit and keep the difference only if it did not go negative.
   always_comb begin
      trial   = {rem, quo[XLEN-1]} - {1'b0, dvs};
      quo_nxt = {quo[XLEN-2:0], 1'b0};
      rem_nxt = {rem[XLEN-2:0], quo[XLEN-1]};
      if (!trial[XLEN]) begin
         quo_nxt = {quo[XLEN-2:0], 1'b1};
         rem_nxt = trial[XLEN-1:0];
      end
   end

   // Operand load on accept; one restoring step per enabled cycle.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         quo <= '0;
         rem <= '0;
         dvs <= '0;
      end else if (load) begin
         quo <= dividend_mag;
         rem <= '0;
         dvs <= divisor_mag;
      end else if (step) begin
         quo <= quo_nxt;
         rem <= rem_nxt;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: accept, 32 restoring steps, sign fix-up, one-cycle done pulse.
// Latency: 33 cycles accept-to-done; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: req sampled only in IDLE; EX stalls until div_done; flush aborts from any state.
module div_ctrl
   import div_ctrl_pkg::*;
(
   input  logic      clk,
   input  logic      rst_b,
   div_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

   state_e          state;
   state_e          state_nxt;
   logic [CNT_W-1:0] cnt;
   logic            accept;
   logic            dp_step;
   logic            last_step;
   logic            rem_sel_q;
   logic            neg_quo_q;
   logic            neg_rem_q;
   logic [XLEN-1:0] result_q;

   logic            op_signed;
   logic            op_rem;
   logic            a_neg;
   logic            b_neg;
   logic            div_zero;
   logic            sig_ovf;
   logic            special;
   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN-1:0] special_res;
   logic [XLEN-1:0] quo_nxt;
   logic [XLEN-1:0] rem_nxt;
   logic [XLEN-1:0] final_res;

   // Operand decode; signed ops run on magnitudes and are fixed up at the end.
   assign op_signed = ~bus.div_opcode[0];
   assign op_rem    = bus.div_opcode[1];
   assign a_neg     = op_signed & bus.div_dividend[XLEN-1];
   assign b_neg     = op_signed & bus.div_divisor[XLEN-1];
   assign a_mag     = neg_if(a_neg, bus.div_dividend);
   assign b_mag     = neg_if(b_neg, bus.div_divisor);

   // Cases that bypass the iteration entirely.
   assign div_zero    = (bus.div_divisor == '0);
   assign sig_ovf     = op_signed && (bus.div_dividend == {1'b1, {(XLEN-1){1'b0}}})
                        && (bus.div_divisor == '1);
   assign special     = div_zero | sig_ovf;
   assign special_res = div_zero ? (op_rem ? bus.div_dividend : '1)
                                 : (op_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   // Quotient negates on differing signs; remainder follows the dividend sign.
   assign final_res = rem_sel_q ? neg_if(neg_rem_q, rem_nxt) : neg_if(neg_quo_q, quo_nxt);
   assign last_step = dp_step && (cnt == '0);

   div_step_dp u_dp (
      .clk          (clk),
      .rst_b        (rst_b),
      .load         (accept),
      .step         (dp_step),
      .dividend_mag (a_mag),
      .divisor_mag  (b_mag),
      .quo_nxt      (quo_nxt),
      .rem_nxt      (rem_nxt)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; flush beats both a new request and the move into DONE.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      dp_step   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.div_req && !bus.div_flush) begin
               accept    = 1'b1;
               state_nxt = special ? DONE : CALC;
            end
         end
         CALC: begin
            if (bus.div_flush) begin
               state_nxt = IDLE;
            end else begin
               dp_step = 1'b1;
               if (cnt == '0) state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Step counter, sign flags and result register; result loads only when DONE is entered.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt       <= '0;
         rem_sel_q <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         if (accept) begin
            cnt       <= CNT_W'(DIV_CYCLES - 1);
            rem_sel_q <= op_rem;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (special) result_q <= special_res;
         end else if (dp_step && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (last_step) result_q <= final_res;
      end
   end

   assign bus.div_busy   = (state == CALC);
   assign bus.div_done   = (state == DONE) && !bus.div_flush;
   assign bus.div_result = result_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: expected result and done cycle queued at drive, compared on div_done.
// Latency: checks 33-cycle normal and 1-cycle special-case timing, flush and async reset.
// Backpressure: req held until div_done, dropped or replaced the following cycle.
module tb_div_ctrl;
   import div_ctrl_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   int   cyc      = 0;
   int   errors   = 0;
   int   checks   = 0;
   int   done_cnt = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   // Free-running cycle index used for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   div_ctrl_if bus();

   div_ctrl dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Output monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      if (bus.div_done) begin
         if (sbq.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            check("result", bus.div_result, e.res);
            check("done_cycle", 32'(cyc), 32'(e.cyc));
         end
         done_cnt++;
      end
   end

   // Drive one operation, queue its expectation and wait (bounded) for div_done.
   task automatic do_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
      exp_t e;
      int   seen;
      bit   ok;
      bus.div_req      = 1'b1;
      bus.div_opcode   = op;
      bus.div_dividend = a;
      bus.div_divisor  = b;
      bus.div_flush    = 1'b0;
      e.res = exp;
      e.cyc = cyc + lat;
      sbq.push_back(e);
      seen = done_cnt;
      ok   = 1'b0;
      for (int i = 0; i < lat + 10; i++) begin
         @(posedge clk); #1;
         if (i == 0) check("busy_cycle1", {31'd0, bus.div_busy}, {31'd0, lat > 1});
         if (done_cnt != seen) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("done_timeout", 32'd0, 32'd1);
         sbq.delete();
      end
      bus.div_req = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] a, b, q, r;
      int start;

      bus.div_req      = 1'b0;
      bus.div_opcode   = DIV_OP_DIV;
      bus.div_dividend = '0;
      bus.div_divisor  = '0;
      bus.div_flush    = 1'b0;

      // Reset state.
      #1;
      check("rst_busy",   {31'd0, bus.div_busy}, 32'd0);
      check("rst_done",   {31'd0, bus.div_done}, 32'd0);
      check("rst_result", bus.div_result, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_b = 1'b1;
      @(posedge clk); #1;

      // Directed operations, back-to-back.
      do_op(DIV_OP_DIV,  32'd100,        32'd7,          32'd14,         33);
      do_op(DIV_OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33);
      do_op(DIV_OP_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33);
      do_op(DIV_OP_DIVU, 32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   33);
      do_op(DIV_OP_REMU, 32'hFFFFFFFF,   32'd2,          32'd1,          33);
      do_op(DIV_OP_DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   33);
      do_op(DIV_OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   33);
      do_op(DIV_OP_REM,  32'd7,          32'hFFFFFFFE,   32'd1,          33);
      do_op(DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFFFFFF,   1);
      do_op(DIV_OP_REM,  32'd5,          32'd0,          32'd5,          1);
      do_op(DIV_OP_REMU, 32'hFFFFFFF0,   32'd0,          32'hFFFFFFF0,   1);
      do_op(DIV_OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1);
      do_op(DIV_OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1);
      do_op(DIV_OP_DIVU, 32'h80000000,   32'hFFFFFFFF,   32'd0,          33);
      do_op(DIV_OP_REMU, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   33);

      // Result holds after done.
      repeat (3) @(posedge clk); #1;
      check("result_hold", bus.div_result, 32'h80000000);

      // Flush at cycle 10, new DIVU accepted at cycle 11.
      bus.div_req      = 1'b1;
      bus.div_opcode   = DIV_OP_DIV;
      bus.div_dividend = 32'd100;
      bus.div_divisor  = 32'd7;
      start = cyc;
      repeat (10) @(posedge clk); #1;
      check("flush_busy_before", {31'd0, bus.div_busy}, 32'd1);
      check("flush_cycle", 32'(cyc - start), 32'd10);
      bus.div_flush = 1'b1;
      @(posedge clk); #1;
      check("flush_busy_after", {31'd0, bus.div_busy}, 32'd0);
      do_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);
      check("flush_total_latency", 32'(cyc - start - 1), 32'd44);

      // Flush on the final step must suppress both done and result update.
      bus.div_req      = 1'b1;
      bus.div_opcode   = DIV_OP_DIV;
      bus.div_dividend = 32'd100;
      bus.div_divisor  = 32'd7;
      repeat (32) @(posedge clk); #1;
      bus.div_flush = 1'b1;
      @(posedge clk); #1;
      bus.div_flush = 1'b0;
      bus.div_req   = 1'b0;
      repeat (3) @(posedge clk); #1;
      check("late_flush_result", bus.div_result, 32'd3);
      check("late_flush_busy", {31'd0, bus.div_busy}, 32'd0);

      // Async reset mid-CALC, then the held request is re-accepted.
      bus.div_req      = 1'b1;
      bus.div_opcode   = DIV_OP_DIV;
      bus.div_dividend = 32'd1000;
      bus.div_divisor  = 32'd10;
      repeat (5) @(posedge clk); #1;
      check("pre_rst_busy", {31'd0, bus.div_busy}, 32'd1);
      rst_b = 1'b0;
      #1;
      check("mid_rst_busy",   {31'd0, bus.div_busy}, 32'd0);
      check("mid_rst_done",   {31'd0, bus.div_done}, 32'd0);
      check("mid_rst_result", bus.div_result, 32'd0);
      @(posedge clk); #1;
      rst_b = 1'b1;
      do_op(DIV_OP_DIV, 32'd1000, 32'd10, 32'd100, 33);

      // Random operands against the language's own division semantics.
      for (int k = 0; k < 8; k++) begin
         a = $urandom;
         b = 32'($urandom_range(1, 65535));
         if (k % 3 == 0) b = -b;
         if (b == 32'hFFFFFFFF) b = 32'd3;
         case (k % 4)
            0: do_op(DIV_OP_DIVU, a, b, a / b, 33);
            1: do_op(DIV_OP_REMU, a, b, a % b, 33);
            2: begin
               q = 32'($signed(a) / $signed(b));
               do_op(DIV_OP_DIV, a, b, q, 33);
            end
            default: begin
               r = 32'($signed(a) % $signed(b));
               do_op(DIV_OP_REM, a, b, r, 33);
            end
         endcase
      end

      repeat (3) @(posedge clk); #1;
      check("scoreboard_empty", 32'(sbq.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
